// File: rtl/de_hazard_ctrl_if.sv
// rtl/de_hazard_ctrl_if.sv - hazard controller hook-up: pipeline status in, stage enables and counters out
interface de_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       fdRsAddr_i;
  logic [4:0]       fdRtAddr_i;
  logic             fdUsesRt_i;
  logic             deMemToRead_i;
  logic [4:0]       deRtAddr_i;
  logic             branchTaken_i;
  logic             memBusy_i;
  logic             clearCounters_i;
  logic             pcWrite_o;
  logic             fdWrite_o;
  logic             fdFlush_o;
  logic             deWrite_o;
  logic             deFlush_o;
  logic             emWrite_o;
  logic             emFlush_o;
  logic [1:0]       state_o;
  logic             error_o;
  logic [CNT_W-1:0] stallCount_o;
  logic [CNT_W-1:0] flushCount_o;

  modport master (
    output fdRsAddr_i, fdRtAddr_i, fdUsesRt_i, deMemToRead_i, deRtAddr_i,
           branchTaken_i, memBusy_i, clearCounters_i,
    input  pcWrite_o, fdWrite_o, fdFlush_o, deWrite_o, deFlush_o, emWrite_o,
           emFlush_o, state_o, error_o, stallCount_o, flushCount_o
  );

  modport slave (
    input  fdRsAddr_i, fdRtAddr_i, fdUsesRt_i, deMemToRead_i, deRtAddr_i,
           branchTaken_i, memBusy_i, clearCounters_i,
    output pcWrite_o, fdWrite_o, fdFlush_o, deWrite_o, deFlush_o, emWrite_o,
           emFlush_o, state_o, error_o, stallCount_o, flushCount_o
  );
endinterface

// File: rtl/de_hazard_ctrl.sv
// rtl/de_hazard_ctrl.sv - 5-stage pipeline sequencing: load-use bubbles, branch flushes, memory waits
module de_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  de_hazard_ctrl_if.slave    bus
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Control vector order: {pcW, fdW, fdF, deW, deF, emW, emF}
  localparam logic [6:0] CTRL_RUN    = 7'b1101010;
  localparam logic [6:0] CTRL_BUBBLE = 7'b0001110;
  localparam logic [6:0] CTRL_BRANCH = 7'b1010101;
  localparam logic [6:0] CTRL_FROZEN = 7'b0000000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2,
    ILLEGAL  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;
  logic [6:0]         ctrl;
  logic               load_use;
  logic               stall_evt;
  logic               flush_evt;

  always_comb begin
    load_use = bus.deMemToRead_i && (bus.deRtAddr_i != 5'd0) &&
               ((bus.deRtAddr_i == bus.fdRsAddr_i) ||
                (bus.fdUsesRt_i && (bus.deRtAddr_i == bus.fdRtAddr_i)));
    ctrl      = CTRL_FROZEN;
    state_d   = state_q;
    wait_d    = wait_q;
    flush_evt = 1'b0;

    case (state_q)
      RUN: begin
        // A busy memory freezes everything; branch/load-use are re-presented afterwards
        if (bus.memBusy_i) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end else if (bus.branchTaken_i) begin
          ctrl      = CTRL_BRANCH;
          flush_evt = 1'b1;
        end else if (load_use) begin
          ctrl = CTRL_BUBBLE;
        end else begin
          ctrl = CTRL_RUN;
        end
      end
      MEM_WAIT: begin
        if (!bus.memBusy_i) begin
          state_d = RUN;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase

    // ERROR and the unreachable encoding both have bit 1 set; neither counts stalls
    stall_evt = !ctrl[6] && !state_q[1];

    if (bus.clearCounters_i) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      stall_d = (stall_evt && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
      flush_d = (flush_evt && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pcWrite_o    = ctrl[6] & rst_ni;
  assign bus.fdWrite_o    = ctrl[5] & rst_ni;
  assign bus.fdFlush_o    = ctrl[4] & rst_ni;
  assign bus.deWrite_o    = ctrl[3] & rst_ni;
  assign bus.deFlush_o    = ctrl[2] & rst_ni;
  assign bus.emWrite_o    = ctrl[1] & rst_ni;
  assign bus.emFlush_o    = ctrl[0] & rst_ni;
  assign bus.state_o      = state_q;
  assign bus.error_o      = state_q[1];
  assign bus.stallCount_o = stall_q;
  assign bus.flushCount_o = flush_q;

endmodule

// File: tb/tb_de_hazard_ctrl.sv
// tb/tb_de_hazard_ctrl.sv - directed bench with per-cycle behavioural model for de_hazard_ctrl
module tb_de_hazard_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;

  localparam int SIT_FROZEN = 0;
  localparam int SIT_RUN    = 1;
  localparam int SIT_BRANCH = 2;
  localparam int SIT_BUBBLE = 3;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  de_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  de_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl();
    return {bus.pcWrite_o, bus.fdWrite_o, bus.fdFlush_o, bus.deWrite_o,
            bus.deFlush_o, bus.emWrite_o, bus.emFlush_o};
  endfunction

  // Model state: mode 0 run, 1 waiting on memory, 2 timed out; run_len counts busy cycles in a wait episode
  int m_mode  = 0;
  int m_run   = 0;
  int m_stall = 0;
  int m_flush = 0;

  always @(negedge clk_i) begin : model
    int         sit;
    logic       lu;
    logic [6:0] e_ctrl;
    if (!rst_ni) begin
      m_mode = 0; m_run = 0; m_stall = 0; m_flush = 0;
    end
    lu = bus.deMemToRead_i && bus.deRtAddr_i != 0 &&
         (bus.deRtAddr_i == bus.fdRsAddr_i || (bus.fdUsesRt_i && bus.deRtAddr_i == bus.fdRtAddr_i));
    if (!rst_ni || m_mode != 0 || bus.memBusy_i) sit = SIT_FROZEN;
    else if (bus.branchTaken_i)                  sit = SIT_BRANCH;
    else if (lu)                                 sit = SIT_BUBBLE;
    else                                         sit = SIT_RUN;
    e_ctrl = {sit == SIT_RUN || sit == SIT_BRANCH,
              sit == SIT_RUN,
              sit == SIT_BRANCH,
              sit == SIT_RUN || sit == SIT_BUBBLE,
              sit == SIT_BRANCH || sit == SIT_BUBBLE,
              sit == SIT_RUN || sit == SIT_BUBBLE,
              sit == SIT_BRANCH};
    check("m_ctrl",  ctrl(),           e_ctrl);
    check("m_state", bus.state_o,      m_mode);
    check("m_error", bus.error_o,      m_mode == 2);
    check("m_stall", bus.stallCount_o, m_stall);
    check("m_flush", bus.flushCount_o, m_flush);
    if (rst_ni) begin
      if (bus.clearCounters_i) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (!e_ctrl[6] && m_mode != 2 && m_stall < MAXC) m_stall++;
        if (sit == SIT_BRANCH && m_flush < MAXC) m_flush++;
      end
      if (m_mode == 0 && bus.memBusy_i) begin
        m_mode = 1; m_run = 1;
      end else if (m_mode == 1) begin
        if (!bus.memBusy_i) m_mode = 0;
        else begin
          m_run++;
          if (m_run > TIMEOUT) m_mode = 2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    bus.fdRsAddr_i = 5'd0; bus.fdRtAddr_i = 5'd0; bus.fdUsesRt_i = 1'b0;
    bus.deMemToRead_i = 1'b0; bus.deRtAddr_i = 5'd0; bus.branchTaken_i = 1'b0;
    bus.memBusy_i = 1'b0; bus.clearCounters_i = 1'b0;
  endtask

  task automatic set_load_use();
    set_idle();
    bus.deMemToRead_i = 1'b1; bus.deRtAddr_i = 5'd8; bus.fdRsAddr_i = 5'd8;
  endtask

  initial begin
    int exp_state[5];
    int busy_pat[5];
    exp_state = '{0, 1, 1, 1, 0};
    busy_pat  = '{1, 1, 1, 0, 0};
    set_idle();
    rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_ctrl", ctrl(), 7'b0000000);
    check("rst_state", bus.state_o, 0);

    tick(); rst_ni = 1'b1;
    @(negedge clk_i);
    check("idle_ctrl", ctrl(), 7'b1101010);
    check("idle_stall", bus.stallCount_o, 0);

    tick(); set_load_use();
    @(negedge clk_i);
    check("lu_ctrl", ctrl(), 7'b0001110);
    tick(); set_idle();
    @(negedge clk_i);
    check("lu_stall", bus.stallCount_o, 1);

    tick(); set_idle(); bus.deMemToRead_i = 1'b1;
    @(negedge clk_i);
    check("lu_r0_ctrl", ctrl(), 7'b1101010);

    tick(); set_idle(); bus.deMemToRead_i = 1'b1; bus.deRtAddr_i = 5'd9;
    bus.fdRtAddr_i = 5'd9; bus.fdRsAddr_i = 5'd3;
    @(negedge clk_i);
    check("lu_rt_unused", ctrl(), 7'b1101010);
    tick(); bus.fdUsesRt_i = 1'b1;
    @(negedge clk_i);
    check("lu_rt_used", ctrl(), 7'b0001110);
    tick(); set_idle();
    @(negedge clk_i);
    check("lu_rt_stall", bus.stallCount_o, 2);

    tick(); set_load_use(); bus.branchTaken_i = 1'b1;
    @(negedge clk_i);
    check("br_ctrl", ctrl(), 7'b1010101);
    tick(); set_idle();
    @(negedge clk_i);
    check("br_flush", bus.flushCount_o, 1);
    check("br_stall", bus.stallCount_o, 2);

    tick(); bus.clearCounters_i = 1'b1;
    tick(); set_idle();
    @(negedge clk_i);
    check("clr_stall", bus.stallCount_o, 0);
    check("clr_flush", bus.flushCount_o, 0);

    for (int i = 0; i < 5; i++) begin
      tick(); bus.memBusy_i = busy_pat[i][0];
      @(negedge clk_i);
      check("mw_state", bus.state_o, exp_state[i]);
      check("mw_pc", bus.pcWrite_o, (i < 4) ? 0 : 1);
    end
    check("mw_stall", bus.stallCount_o, 4);

    for (int i = 0; i < 17; i++) begin
      tick(); bus.memBusy_i = 1'b1;
      @(negedge clk_i);
      if (i == 16) check("to_pre_state", bus.state_o, 1);
    end
    tick(); bus.memBusy_i = 1'b0;
    @(negedge clk_i);
    check("to_state", bus.state_o, 2);
    check("to_error", bus.error_o, 1);
    check("to_ctrl", ctrl(), 7'b0000000);
    check("to_stall_sat", bus.stallCount_o, MAXC);
    tick(); bus.clearCounters_i = 1'b1;
    tick(); bus.clearCounters_i = 1'b0;
    tick();
    @(negedge clk_i);
    check("err_no_count", bus.stallCount_o, 0);
    check("err_sticky", bus.state_o, 2);

    tick(); rst_ni = 1'b0;
    @(negedge clk_i);
    check("rst2_state", bus.state_o, 0);
    check("rst2_error", bus.error_o, 0);
    tick(); rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst2_ctrl", ctrl(), 7'b1101010);

    for (int k = 1; k <= 20; k++) begin
      tick(); set_load_use(); bus.clearCounters_i = (k == 18);
      @(negedge clk_i);
      if (k == 18) check("sat_15", bus.stallCount_o, 15);
      if (k == 19) check("sat_clr", bus.stallCount_o, 0);
    end
    tick(); set_idle();
    @(negedge clk_i);
    check("sat_end", bus.stallCount_o, 2);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/de_hazard_ctrl.md
Name: de_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage datapath.
- Drives the write-enable and flush controls of the PC, the fetch/decode buffer, the decode/execute buffer and the execute/memory buffer.
- Handles three cases: load-use stalls (bubble inserted into the decode/execute buffer), taken-branch flushes, and multi-cycle data-memory waits with a timeout watchdog.
- Keeps saturating stall and flush counters for performance visibility.

Parameters:
TIMEOUT, 16, MEM_WAIT cycles tolerated with memBusy_i high before ERROR (>=1)
CNT_W, 16, width of the stall and flush counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
fdRsAddr_i  in  5  rs of the instruction in decode
fdRtAddr_i  in  5  rt of the instruction in decode
fdUsesRt_i  in  1  decode instruction reads rt as a source
deMemToRead_i  in  1  instruction in execute is a load
deRtAddr_i  in  5  load destination register in execute
branchTaken_i  in  1  branch resolved taken in the memory stage
memBusy_i  in  1  data memory not ready this cycle
clearCounters_i  in  1  synchronous clear of both counters
pcWrite_o  out  1  PC load enable
fdWrite_o  out  1  fetch/decode buffer write enable
fdFlush_o  out  1  fetch/decode buffer flush (loads NOP)
deWrite_o  out  1  decode/execute buffer write enable
deFlush_o  out  1  decode/execute buffer flush (all control bits 0)
emWrite_o  out  1  execute/memory buffer write enable
emFlush_o  out  1  execute/memory buffer flush
state_o  out  2  current state: RUN=0, MEM_WAIT=1, ERROR=2
error_o  out  1  memory timeout; sticky until reset
stallCount_o  out  CNT_W  cycles with pcWrite_o=0 while not in ERROR
flushCount_o  out  CNT_W  number of branch flushes

Behaviour:
- Reset (async, rst_ni=0): state=RUN, waitCnt=0, both counters 0, error_o=0. While rst_ni=0, all write and flush outputs are forced to 0.
- Write/flush outputs are combinational from the registered state and the current inputs. State, waitCnt and counters update on posedge clk_i.
- loadUse = deMemToRead_i && deRtAddr_i!=0 && (deRtAddr_i==fdRsAddr_i || (fdUsesRt_i && deRtAddr_i==fdRtAddr_i)).
- Priority inside RUN: memBusy_i > branchTaken_i > loadUse > normal.
- RUN, normal: all writes=1, all flushes=0.
- RUN, loadUse: pcWrite=0, fdWrite=0, deWrite=1, deFlush=1 (bubble), emWrite=1. One-cycle stall; the next cycle re-evaluates with the load now in memory, so loadUse clears.
- RUN, branchTaken_i: pcWrite=1 (target loaded), fdFlush=deFlush=emFlush=1, fdWrite=deWrite=emWrite=0. flushCount increments. A branch overrides a simultaneous loadUse.
- RUN, memBusy_i:
  - All writes=0, all flushes=0.
  - next state=MEM_WAIT, waitCnt<=0.
  - A simultaneous branch or loadUse is ignored this cycle. The pipeline is frozen, so the same inputs are re-presented after the wait.
- MEM_WAIT: all writes=0, flushes=0.
  - memBusy_i=0 -> RUN, with one recovery cycle before re-evaluation.
  - memBusy_i=1 and waitCnt==TIMEOUT-1 -> ERROR.
  - Otherwise waitCnt++.
- ERROR: all writes=0, flushes=0, error_o=1. Exits only on reset.
- stallCount increments every cycle with pcWrite_o=0 and state!=ERROR. This covers RUN stalls and all MEM_WAIT cycles, including the RUN cycle in which memBusy_i is first seen.
- Both counters saturate at 2^CNT_W-1.
- clearCounters_i clears both counters and has priority over a same-cycle increment.
- Encoding 3 is unreachable; if it occurs, the next state is RUN and outputs match ERROR.

Test Plan:
- Reset, then idle inputs -> pcWrite/fdWrite/deWrite/emWrite=1, flushes=0, state_o=0, counters 0. While rst_ni=0, all enables read 0.
- deMemToRead_i=1, deRtAddr_i=8, fdRsAddr_i=8 for 1 cycle -> that cycle pcWrite=0, fdWrite=0, deFlush=1, deWrite=1; stallCount=1. Repeating with deRtAddr_i=0 gives no stall. Repeating with an rt match and fdUsesRt_i=0 gives no stall.
- branchTaken_i=1 while loadUse is also true -> fdFlush=deFlush=emFlush=1, pcWrite=1, no stall; flushCount=1, stallCount unchanged.
- memBusy_i high 3 cycles, then low -> state 0,1,1,1,0. All writes 0 for 4 cycles (3 busy cycles plus the 1 recovery cycle), then resume; stallCount=4.
- TIMEOUT=16, memBusy_i held high 17 cycles -> state_o=2, error_o=1 on cycle 17. Remains there with memBusy_i dropped. Reset returns state_o=0, error_o=0.
- CNT_W=4, 20 load-use stalls with clearCounters_i pulsed at stall 18 -> stallCount reads 15 at stall 17, 0 after the clear, 2 after the last stall.
